// File: rtl/l2_req_ctrl.sv
// l2_req_ctrl: drains the L2 request FIFO one word request at a time and
// issues it to the backing memory port. Writes are posted; reads wait for
// memory data (bounded by TIMEOUT) and return it on a response channel.
// Optional feature macro: L2_REQ_CTRL_STATS_EN adds saturating counters
// stat_rd_cnt / stat_wr_cnt / stat_to_cnt.
module l2_req_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2fifo_l2_req,
    input  logic [29:0]       l2fifo_l2_addr,
    input  logic              l2fifo_l2_wen,
    input  logic [3:0]        l2fifo_l2_wmask,
    input  logic [31:0]       l2fifo_l2_wdata,
    output logic              l2_l2fifo_ready,
    output logic              l2_mem_req,
    output logic [29:0]       l2_mem_addr,
    output logic              l2_mem_wen,
    output logic [3:0]        l2_mem_wmask,
    output logic [31:0]       l2_mem_wdata,
    input  logic              mem_l2_ready,
    input  logic              mem_l2_valid,
    input  logic [31:0]       mem_l2_rdata,
    output logic              l2_dc_resp_valid,
    output logic [29:0]       l2_dc_resp_addr,
    output logic [31:0]       l2_dc_resp_data,
    output logic              l2_dc_resp_err,
    input  logic              dc_l2_resp_ready
`ifdef L2_REQ_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_rd_cnt,
    output logic [CNT_W-1:0]  stat_wr_cnt,
    output logic [CNT_W-1:0]  stat_to_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Last counter value before a read is forced to complete with error.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [29:0]       addr_q;
    logic              wen_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              timeout;

    assign accept  = (state == IDLE) && l2fifo_l2_req;
    // Valid data wins over a coincident timeout.
    assign timeout = (state == WAIT) && !mem_l2_valid && (cnt == CNT_LAST);

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_nx         = state;
        l2_l2fifo_ready  = 1'b0;
        l2_mem_req       = 1'b0;
        l2_dc_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                l2_l2fifo_ready = 1'b1;
                if (l2fifo_l2_req) state_nx = ISSUE;
            end
            ISSUE: begin
                l2_mem_req = 1'b1;
                if (mem_l2_ready) state_nx = wen_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_l2_valid || timeout) state_nx = RESP;
            end
            RESP: begin
                l2_dc_resp_valid = 1'b1;
                if (dc_l2_resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, wait counter and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= l2fifo_l2_addr;
                wen_q   <= l2fifo_l2_wen;
                wmask_q <= l2fifo_l2_wmask;
                wdata_q <= l2fifo_l2_wdata;
            end
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (state == WAIT && mem_l2_valid) begin
                rdata_q <= mem_l2_rdata;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign l2_mem_addr     = addr_q;
    assign l2_mem_wen      = wen_q;
    assign l2_mem_wmask    = wmask_q;
    assign l2_mem_wdata    = wdata_q;
    assign l2_dc_resp_addr = addr_q;
    assign l2_dc_resp_data = rdata_q;
    assign l2_dc_resp_err  = err_q;

`ifdef L2_REQ_CTRL_STATS_EN
    // Saturating accept/timeout statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else begin
            if (accept && !l2fifo_l2_wen && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (accept &&  l2fifo_l2_wen && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (timeout && stat_to_cnt != '1) stat_to_cnt <= stat_to_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_req_ctrl.sv
// Bench for l2_req_ctrl: directed reset/write checks, then randomized
// traffic with a queue scoreboard checked by an independent monitor.
module tb_l2_req_ctrl;

    localparam int TO = 4;
    localparam int N  = 60;

    typedef struct packed {
        logic [29:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        wen;
        int          s;      // cycles of mem_l2_ready stall after request seen
        int          k;      // WAIT cycle (0-based) on which data is returned
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic        err;
        int          k;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // directed-phase and random-phase drivers, muxed by auto_en
    logic        auto_en = 1'b0;
    logic        d_req, a_req;
    req_t        d_head, a_head;
    logic        d_mready, a_mready, d_mvalid, a_mvalid, a_rready;
    logic [31:0] d_rdata, a_rdata;

    logic        l2fifo_l2_req, l2_l2fifo_ready, l2_mem_req, l2_mem_wen;
    logic [29:0] l2fifo_l2_addr, l2_mem_addr, l2_dc_resp_addr;
    logic        l2fifo_l2_wen, l2_dc_resp_valid, l2_dc_resp_err;
    logic [3:0]  l2fifo_l2_wmask, l2_mem_wmask;
    logic [31:0] l2fifo_l2_wdata, l2_mem_wdata, mem_l2_rdata, l2_dc_resp_data;
    logic        mem_l2_ready, mem_l2_valid, dc_l2_resp_ready;
    req_t        head;
`ifdef L2_REQ_CTRL_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt, stat_to_cnt;
    int          m_rd, m_wr, m_to;
`endif

    assign head             = auto_en ? a_head : d_head;
    assign l2fifo_l2_req    = auto_en ? a_req : d_req;
    assign l2fifo_l2_addr   = head.addr;
    assign l2fifo_l2_wen    = head.wen;
    assign l2fifo_l2_wmask  = head.wmask;
    assign l2fifo_l2_wdata  = head.wdata;
    assign mem_l2_ready     = auto_en ? a_mready : d_mready;
    assign mem_l2_valid     = auto_en ? a_mvalid : d_mvalid;
    assign mem_l2_rdata     = auto_en ? a_rdata : d_rdata;
    assign dc_l2_resp_ready = auto_en ? a_rready : 1'b1;

    l2_req_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst_n),
        .l2fifo_l2_req(l2fifo_l2_req), .l2fifo_l2_addr(l2fifo_l2_addr),
        .l2fifo_l2_wen(l2fifo_l2_wen), .l2fifo_l2_wmask(l2fifo_l2_wmask),
        .l2fifo_l2_wdata(l2fifo_l2_wdata), .l2_l2fifo_ready(l2_l2fifo_ready),
        .l2_mem_req(l2_mem_req), .l2_mem_addr(l2_mem_addr), .l2_mem_wen(l2_mem_wen),
        .l2_mem_wmask(l2_mem_wmask), .l2_mem_wdata(l2_mem_wdata),
        .mem_l2_ready(mem_l2_ready), .mem_l2_valid(mem_l2_valid), .mem_l2_rdata(mem_l2_rdata),
        .l2_dc_resp_valid(l2_dc_resp_valid), .l2_dc_resp_addr(l2_dc_resp_addr),
        .l2_dc_resp_data(l2_dc_resp_data), .l2_dc_resp_err(l2_dc_resp_err),
        .dc_l2_resp_ready(dc_l2_resp_ready)
`ifdef L2_REQ_CTRL_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_to_cnt(stat_to_cnt)
`endif
    );

    req_t  exp_mem_q[$];
    resp_t exp_resp_q[$];
    plan_t plan_q[$];
    int    n_cmp = 0, n_bad = 0;
    logic  drv_done = 1'b0, drv_stuck = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", nm, cyc);
    endtask

    // Random FIFO producer; builds expectations from the request and plan.
    initial begin
        a_req = 1'b0;
        a_head = '0;
`ifdef L2_REQ_CTRL_STATS_EN
        m_rd = 0; m_wr = 1; m_to = 0;   // m_wr starts at the directed write
`endif
        wait (auto_en);
        for (int i = 0; i < N && !drv_stuck; i++) begin
            req_t  h;
            plan_t p;
            resp_t r;
            int    w;
            h.addr = 30'($urandom); h.wen = 1'($urandom_range(0, 1));
            h.wmask = 4'($urandom); h.wdata = $urandom;
            p.wen = h.wen; p.s = $urandom_range(0, 3);
            p.k = $urandom_range(0, TO + 2); p.rdata = $urandom;
            exp_mem_q.push_back(h);
            plan_q.push_back(p);
            if (!h.wen) begin
                r.addr = h.addr; r.err = (p.k >= TO);
                r.data = r.err ? 32'h0 : p.rdata; r.k = p.k;
                exp_resp_q.push_back(r);
            end
`ifdef L2_REQ_CTRL_STATS_EN
            if (h.wen) m_wr++; else m_rd++;
            if (!h.wen && p.k >= TO) m_to++;
`endif
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) begin
                @(posedge clk); #1;
            end
            a_req = 1'b1; a_head = h; w = 0;
            forever begin
                @(negedge clk);
                if (l2_l2fifo_ready) break;
                w++;
                if (w > 500) begin drv_stuck = 1'b1; break; end
            end
            @(posedge clk); #1;
            a_req = 1'b0; a_head = req_t'({$urandom, $urandom, 3'($urandom)});
        end
        drv_done = 1'b1;
    end

    // Memory model: stalls ready per plan, returns read data k WAIT cycles later.
    initial begin
        a_mready = 1'b0; a_mvalid = 1'b0; a_rdata = '0;
        wait (auto_en);
        forever begin
            plan_t p;
            int    seen;
            wait (plan_q.size() > 0);
            p = plan_q.pop_front();
            seen = 0;
            a_mready = (p.s == 0);
            forever begin
                @(negedge clk);
                if (l2_mem_req) begin
                    if (a_mready) break;
                    seen++;
                end
                @(posedge clk); #1;
                a_mready = (seen >= p.s);
            end
            @(posedge clk); #1;
            a_mready = 1'b0;
            if (!p.wen) begin
                repeat (p.k) begin @(posedge clk); #1; end
                a_mvalid = 1'b1; a_rdata = p.rdata;
                @(posedge clk); #1;
                a_mvalid = 1'b0; a_rdata = $urandom;
            end
        end
    end

    // Response consumer with random backpressure.
    initial begin
        a_rready = 1'b0;
        wait (auto_en);
        forever begin
            @(posedge clk); #1;
            a_rready = ($urandom_range(0, 9) < 5);
        end
    end

    initial begin
        rst_n = 1'b0; d_req = 1'b0; d_head = '0;
        d_mready = 1'b0; d_mvalid = 1'b0; d_rdata = '0;

        // reset state
        @(negedge clk);
        chk("rst_fifo_ready", l2_l2fifo_ready, 1);
        chk("rst_mem_req", l2_mem_req, 0);
        chk("rst_mem_addr", l2_mem_addr, 0);
        chk("rst_mem_wen", l2_mem_wen, 0);
        chk("rst_mem_wmask", l2_mem_wmask, 0);
        chk("rst_mem_wdata", l2_mem_wdata, 0);
        chk("rst_resp_valid", l2_dc_resp_valid, 0);
        chk("rst_resp_data", l2_dc_resp_data, 0);
        chk("rst_resp_err", l2_dc_resp_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // read to byte 0x100 (word 0x40), reset while in WAIT
        d_req = 1'b1; d_head = '{addr: 30'h40, wen: 1'b0, wmask: 4'h0, wdata: 32'h0};
        @(posedge clk); #1 d_req = 1'b0; d_mready = 1'b1;
        @(negedge clk);
        chk("rdmw_mem_req", l2_mem_req, 1);
        chk("rdmw_mem_addr", l2_mem_addr, 30'h40);
        @(posedge clk); #1 d_mready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rdmw_async_ready", l2_l2fifo_ready, 1);
        chk("rdmw_async_mem_req", l2_mem_req, 0);
        chk("rdmw_async_resp", l2_dc_resp_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1; d_mvalid = 1'b1; d_rdata = 32'h5555AAAA;
        @(posedge clk); #1 d_mvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rdmw_late_resp", l2_dc_resp_valid, 0);
            chk("rdmw_late_ready", l2_l2fifo_ready, 1);
        end

        // posted write: word 0x10, mask 0011, DEADBEEF, memory always ready
        @(posedge clk); #1;
        d_req = 1'b1; d_mready = 1'b1;
        d_head = '{addr: 30'h10, wen: 1'b1, wmask: 4'b0011, wdata: 32'hDEADBEEF};
        @(negedge clk);
        chk("wr_c0_ready", l2_l2fifo_ready, 1);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        chk("wr_c1_mem_req", l2_mem_req, 1);
        chk("wr_c1_addr", l2_mem_addr, 30'h10);
        chk("wr_c1_wen", l2_mem_wen, 1);
        chk("wr_c1_wmask", l2_mem_wmask, 4'b0011);
        chk("wr_c1_wdata", l2_mem_wdata, 32'hDEADBEEF);
        chk("wr_c1_ready", l2_l2fifo_ready, 0);
        @(negedge clk);
        chk("wr_c2_mem_req", l2_mem_req, 0);
        chk("wr_c2_ready", l2_l2fifo_ready, 1);
        chk("wr_c2_resp", l2_dc_resp_valid, 0);
        @(posedge clk); #1 d_mready = 1'b0;

        // random phase
        auto_en = 1'b1;
        fork
            begin : monitor
                int   hs_cyc;
                logic first;
                hs_cyc = 0; first = 1'b1;
                forever begin
                    @(negedge clk);
                    if (l2_mem_req) begin
                        chk("busy_fifo_ready", l2_l2fifo_ready, 0);
                        if (exp_mem_q.size() == 0) flag("mem_unexpected");
                        else begin
                            req_t e;
                            e = exp_mem_q[0];
                            chk("mem_addr", l2_mem_addr, e.addr);
                            chk("mem_wen", l2_mem_wen, e.wen);
                            chk("mem_wmask", l2_mem_wmask, e.wmask);
                            chk("mem_wdata", l2_mem_wdata, e.wdata);
                            if (mem_l2_ready) begin
                                void'(exp_mem_q.pop_front());
                                if (!e.wen) hs_cyc = cyc;
                            end
                        end
                    end
                    if (l2_dc_resp_valid) begin
                        chk("resp_fifo_ready", l2_l2fifo_ready, 0);
                        if (exp_resp_q.size() == 0) flag("resp_unexpected");
                        else begin
                            resp_t r;
                            r = exp_resp_q[0];
                            if (first) chk("resp_latency", 32'(cyc),
                                           32'(hs_cyc + 2 + ((r.k < TO) ? r.k : TO - 1)));
                            first = 1'b0;
                            chk("resp_addr", l2_dc_resp_addr, r.addr);
                            chk("resp_data", l2_dc_resp_data, r.data);
                            chk("resp_err", l2_dc_resp_err, r.err);
                            if (dc_l2_resp_ready) begin
                                void'(exp_resp_q.pop_front());
                                first = 1'b1;
                            end
                        end
                    end
                end
            end
        join_none

        begin
            int w;
            w = 0;
            while (w < 20000 && !(drv_done && exp_mem_q.size() == 0 && exp_resp_q.size() == 0)) begin
                @(posedge clk);
                w++;
            end
            if (w >= 20000) flag("drain_timeout");
        end
        if (drv_stuck) flag("fifo_pop_timeout");
        repeat (3) @(negedge clk);
        chk("final_resp_idle", l2_dc_resp_valid, 0);
`ifdef L2_REQ_CTRL_STATS_EN
        chk("stat_rd_cnt", 32'(stat_rd_cnt), 32'(m_rd));
        chk("stat_wr_cnt", 32'(stat_wr_cnt), 32'(m_wr));
        chk("stat_to_cnt", 32'(stat_to_cnt), 32'(m_to));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
